// File: rtl/video_avs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_avs_pkg
// Purpose  : Shared definitions for the video core Avalon-MM register block.
//            The system control initiator uses the same map and CTRL layout.
// Contents : register word addresses, CTRL bit indices, CTRL struct,
//            pending-commit state encoding, STATUS field positions.
// Revision : 1.0 - initial release
// ============================================================================
package video_avs_pkg;

   // Register word addresses. Only address[1:0] is decoded.
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PARAM  = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_ID     = 2'd3;

   // CTRL bit positions
   localparam int CTRL_BYPASS_BIT = 0;

   // STATUS field positions
   localparam int FRAME_CNT_W        = 16;
   localparam int STATUS_PENDING_BIT = 16;

   // CTRL layout: bit 0 is bypass, the rest is stored and read back only.
   typedef struct packed {
      logic [30:0] reserved;
      logic        bypass;
   } ctrl_t;

   // Commit tracker: IDLE means staged == active, PENDING awaits a commit.
   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } pend_state_t;

endpackage
`default_nettype wire

// File: rtl/video_core_avs_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : video_core_avs_regs_if
// Purpose  : Avalon-MM bus bundle between the system control initiator
//            (master) and a video core register block (slave).
// Signals  : avs_address[ADDR_W], avs_write, avs_writedata[32], avs_read
//            (master->slave); avs_readdata[32], avs_readdatavalid
//            (slave->master). No waitrequest: every access is accepted.
// Revision : 1.0 - initial release
// ============================================================================
interface video_core_avs_regs_if #(
   parameter int ADDR_W = 2
);
   logic [ADDR_W-1:0] avs_address;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic              avs_read;
   logic [31:0]       avs_readdata;
   logic              avs_readdatavalid;

   modport master (
      output avs_address, avs_write, avs_writedata, avs_read,
      input  avs_readdata, avs_readdatavalid
   );

   modport slave (
      input  avs_address, avs_write, avs_writedata, avs_read,
      output avs_readdata, avs_readdatavalid
   );
endinterface
`default_nettype wire

// File: rtl/video_shadow_reg.sv
`default_nettype none
// ============================================================================
// Module   : video_shadow_reg
// Purpose  : Staged/active register pair. Writes land in the staged copy;
//            commit copies staged into active. When write and commit share
//            an edge, active receives the pre-write staged value.
// Ports    : sys_clk, sys_rst (sync, active-low), wr_en, wr_data[WIDTH],
//            commit, staged[WIDTH], active[ACT_W] (low bits of staged only,
//            since the datapath may consume just part of the register).
// Revision : 1.0 - initial release
// ============================================================================
module video_shadow_reg #(
   parameter int               WIDTH   = 32,
   parameter int               ACT_W   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             commit,
   output logic [WIDTH-1:0] staged,
   output logic [ACT_W-1:0] active
);

   localparam logic [ACT_W-1:0] ACT_RST = RST_VAL[ACT_W-1:0];

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         staged <= RST_VAL;
         active <= ACT_RST;
      end else begin
         if (wr_en) begin
            staged <= wr_data;
         end
         // Non-blocking read of staged gives the pre-write value on a shared edge.
         if (commit) begin
            active <= staged[ACT_W-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/video_core_avs_regs.sv
`default_nettype none
// ============================================================================
// Module   : video_core_avs_regs
// Purpose  : Avalon-MM responder register block for a video pipeline core.
//            Staged CTRL/PARAM are committed to the active copy either on
//            frame_start (FRAME_SYNC=1) or on the edge after a write
//            (FRAME_SYNC=0). Reads return with a fixed one-cycle latency.
// Ports    : sys_clk, sys_rst (sync, active-low), avs (bus slave modport),
//            frame_start (1-cycle pulse), core_bypass, core_param[32],
//            update_pending.
// Map      : 0 CTRL (RW), 1 PARAM (RW), 2 STATUS (RO), 3 ID (RO).
// Revision : 1.0 - initial release
// ============================================================================
module video_core_avs_regs
   import video_avs_pkg::*;
#(
   parameter int          ADDR_W     = 2,
   parameter logic [31:0] CORE_ID    = 32'h0000_0000,
   parameter bit          FRAME_SYNC = 1'b1,
   parameter logic [31:0] CTRL_RST   = 32'h0000_0001,
   parameter logic [31:0] PARAM_RST  = 32'h0000_0000
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   video_core_avs_regs_if.slave  avs,
   input  logic                  frame_start,
   output logic                  core_bypass,
   output logic [31:0]           core_param,
   output logic                  update_pending
);

   // ------------------------------------------------------------------
   // Address decode: bits above [1:0] are ignored.
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] addr;
   logic [1:0]        reg_sel;
   logic              wr_ctrl;
   logic              wr_param;
   logic              wr_any;
   logic              rd_accept;

   assign addr     = avs.avs_address;
   assign reg_sel  = addr[1:0];
   assign wr_ctrl  = avs.avs_write && (reg_sel == REG_CTRL);
   assign wr_param = avs.avs_write && (reg_sel == REG_PARAM);
   assign wr_any   = wr_ctrl || wr_param;
   // A read colliding with a write is dropped.
   assign rd_accept = avs.avs_read && !avs.avs_write;

   // ------------------------------------------------------------------
   // Commit decision
   // ------------------------------------------------------------------
   pend_state_t state;
   logic        commit;

   generate
      if (FRAME_SYNC) begin : g_frame_commit
         assign commit = frame_start && (state == ST_PENDING);
      end else begin : g_write_commit
         assign commit = (state == ST_PENDING);
      end
   endgenerate

   // ------------------------------------------------------------------
   // Shadow register pairs
   // ------------------------------------------------------------------
   logic [31:0] ctrl_staged_vec;
   logic [0:0]  ctrl_active;
   logic [31:0] param_staged;
   ctrl_t       ctrl_staged;

   video_shadow_reg #(
      .WIDTH   (32),
      .ACT_W   (1),
      .RST_VAL (CTRL_RST)
   ) u_ctrl (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .wr_en   (wr_ctrl),
      .wr_data (avs.avs_writedata),
      .commit  (commit),
      .staged  (ctrl_staged_vec),
      .active  (ctrl_active)
   );

   video_shadow_reg #(
      .WIDTH   (32),
      .ACT_W   (32),
      .RST_VAL (PARAM_RST)
   ) u_param (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .wr_en   (wr_param),
      .wr_data (avs.avs_writedata),
      .commit  (commit),
      .staged  (param_staged),
      .active  (core_param)
   );

   assign ctrl_staged = ctrl_t'(ctrl_staged_vec);
   assign core_bypass = ctrl_active[CTRL_BYPASS_BIT];

   // ------------------------------------------------------------------
   // Pending FSM: a write on the commit edge keeps the block pending so
   // the newer staged value commits on the next opportunity.
   // ------------------------------------------------------------------
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         state          <= ST_IDLE;
         update_pending <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (wr_any) begin
                  state          <= ST_PENDING;
                  update_pending <= 1'b1;
               end
            end
            ST_PENDING: begin
               if (commit && !wr_any) begin
                  state          <= ST_IDLE;
                  update_pending <= 1'b0;
               end
            end
            default: begin
               state          <= ST_IDLE;
               update_pending <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Frame counter (wraps naturally at 16 bits)
   // ------------------------------------------------------------------
   logic [FRAME_CNT_W-1:0] frame_cnt;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         frame_cnt <= '0;
      end else if (frame_start) begin
         frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Read-back path
   // ------------------------------------------------------------------
   logic [31:0] status_word;
   logic [31:0] rd_mux;

   always_comb begin
      status_word                          = '0;
      status_word[FRAME_CNT_W-1:0]         = frame_cnt;
      status_word[STATUS_PENDING_BIT]      = update_pending;
   end

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         REG_CTRL:   rd_mux = ctrl_staged;
         REG_PARAM:  rd_mux = param_staged;
         REG_STATUS: rd_mux = status_word;
         REG_ID:     rd_mux = CORE_ID;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         avs.avs_readdata      <= '0;
         avs.avs_readdatavalid <= 1'b0;
      end else begin
         avs.avs_readdatavalid <= rd_accept;
         if (rd_accept) begin
            avs.avs_readdata <= rd_mux;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_video_core_avs_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_core_avs_regs
// Purpose  : Directed self-checking bench for video_core_avs_regs. dut0 uses
//            frame-synchronous commit, dut1 commits on the edge after a write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_core_avs_regs;

   localparam logic [31:0] ID0 = 32'hC0DE_0001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fs0 = 1'b0;
   logic        fs1 = 1'b0;
   logic        bypass0, bypass1;
   logic [31:0] param0, param1;
   logic        pend0, pend1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   video_core_avs_regs_if #(.ADDR_W(2)) bus0 ();
   video_core_avs_regs_if #(.ADDR_W(2)) bus1 ();

   video_core_avs_regs #(
      .ADDR_W(2), .CORE_ID(ID0), .FRAME_SYNC(1'b1),
      .CTRL_RST(32'h0000_0001), .PARAM_RST(32'h0000_0000)
   ) dut0 (
      .sys_clk(clk), .sys_rst(rst_n), .avs(bus0.slave), .frame_start(fs0),
      .core_bypass(bypass0), .core_param(param0), .update_pending(pend0)
   );

   video_core_avs_regs #(
      .ADDR_W(2), .CORE_ID(32'h0000_0000), .FRAME_SYNC(1'b0),
      .CTRL_RST(32'h0000_0001), .PARAM_RST(32'h0000_0000)
   ) dut1 (
      .sys_clk(clk), .sys_rst(rst_n), .avs(bus1.slave), .frame_start(fs1),
      .core_bypass(bypass1), .core_param(param1), .update_pending(pend1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus0.avs_address = a; bus0.avs_writedata = d; bus0.avs_write = 1'b1;
      tick();
      bus0.avs_write = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic v, output logic [31:0] d);
      bus0.avs_address = a; bus0.avs_read = 1'b1;
      tick();
      bus0.avs_read = 1'b0;
      v = bus0.avs_readdatavalid;
      d = bus0.avs_readdata;
   endtask

   task automatic frame_pulse();
      fs0 = 1'b1;
      tick();
      fs0 = 1'b0;
   endtask

   task automatic test_reset();
      logic v; logic [31:0] d;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tests++; if (bypass0 !== 1'b1) begin fails++; $display("FAIL reset_bypass got %h exp 1", bypass0); end
      tests++; if (param0 !== 32'h0) begin fails++; $display("FAIL reset_param got %h exp 0", param0); end
      tests++; if (pend0 !== 1'b0) begin fails++; $display("FAIL reset_pending got %h exp 0", pend0); end
      tests++; if (bus0.avs_readdatavalid !== 1'b0) begin fails++; $display("FAIL reset_rdv got %h exp 0", bus0.avs_readdatavalid); end
      bus_read(2'd2, v, d);
      tests++; if (v !== 1'b1) begin fails++; $display("FAIL reset_status_valid got %h exp 1", v); end
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_status got %h exp 00000000", d); end
   endtask

   task automatic test_frame_sync();
      bus_write(2'd1, 32'hDEAD_BEEF);
      tests++; if (pend0 !== 1'b1) begin fails++; $display("FAIL fsync_pending got %h exp 1", pend0); end
      tests++; if (param0 !== 32'h0) begin fails++; $display("FAIL fsync_param_hold got %h exp 0", param0); end
      frame_pulse();
      tests++; if (param0 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL fsync_param_commit got %h exp deadbeef", param0); end
      tests++; if (pend0 !== 1'b0) begin fails++; $display("FAIL fsync_pending_clr got %h exp 0", pend0); end
   endtask

   task automatic test_same_edge();
      bus_write(2'd0, 32'h0);
      frame_pulse();
      tests++; if (bypass0 !== 1'b0) begin fails++; $display("FAIL same_edge_first got %h exp 0", bypass0); end
      bus0.avs_address = 2'd0; bus0.avs_writedata = 32'h1; bus0.avs_write = 1'b1; fs0 = 1'b1;
      tick();
      bus0.avs_write = 1'b0; fs0 = 1'b0;
      tests++; if (bypass0 !== 1'b0) begin fails++; $display("FAIL same_edge_bypass got %h exp 0", bypass0); end
      tests++; if (pend0 !== 1'b1) begin fails++; $display("FAIL same_edge_pending got %h exp 1", pend0); end
      frame_pulse();
      tests++; if (bypass0 !== 1'b1) begin fails++; $display("FAIL same_edge_second got %h exp 1", bypass0); end
      tests++; if (pend0 !== 1'b0) begin fails++; $display("FAIL same_edge_pend_clr got %h exp 0", pend0); end
   endtask

   task automatic test_readback();
      logic v; logic [31:0] d;
      bus_write(2'd1, 32'h1234_5678);
      bus_read(2'd1, v, d);
      tests++; if (v !== 1'b1) begin fails++; $display("FAIL rb_param_valid got %h exp 1", v); end
      tests++; if (d !== 32'h1234_5678) begin fails++; $display("FAIL rb_param got %h exp 12345678", d); end
      tick();
      tests++; if (bus0.avs_readdatavalid !== 1'b0) begin fails++; $display("FAIL rb_valid_pulse got %h exp 0", bus0.avs_readdatavalid); end
      tests++; if (bus0.avs_readdata !== 32'h1234_5678) begin fails++; $display("FAIL rb_data_hold got %h exp 12345678", bus0.avs_readdata); end
      // Four frames so far and PARAM still pending
      bus_read(2'd2, v, d);
      tests++; if (d !== 32'h0001_0004) begin fails++; $display("FAIL rb_status got %h exp 00010004", d); end
      bus_read(2'd3, v, d);
      tests++; if (d !== ID0) begin fails++; $display("FAIL rb_id got %h exp %h", d, ID0); end
      bus_write(2'd3, 32'hFFFF_FFFF);
      bus_read(2'd3, v, d);
      tests++; if (d !== ID0) begin fails++; $display("FAIL rb_id_after_wr got %h exp %h", d, ID0); end
      tests++; if (param0 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rb_active_param got %h exp deadbeef", param0); end
   endtask

   task automatic test_read_write_collision();
      logic v; logic [31:0] d;
      bus0.avs_address = 2'd0; bus0.avs_writedata = 32'hA5A5_A5A4;
      bus0.avs_write = 1'b1; bus0.avs_read = 1'b1;
      tick();
      bus0.avs_write = 1'b0; bus0.avs_read = 1'b0;
      tests++; if (bus0.avs_readdatavalid !== 1'b0) begin fails++; $display("FAIL rw_drop got %h exp 0", bus0.avs_readdatavalid); end
      bus_read(2'd0, v, d);
      tests++; if (v !== 1'b1) begin fails++; $display("FAIL rw_read_valid got %h exp 1", v); end
      tests++; if (d !== 32'hA5A5_A5A4) begin fails++; $display("FAIL rw_read got %h exp a5a5a5a4", d); end
   endtask

   task automatic test_counter_wrap();
      logic v; logic [31:0] d;
      bus_write(2'd1, 32'h0000_0055);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tests++; if (pend0 !== 1'b0) begin fails++; $display("FAIL midrst_pending got %h exp 0", pend0); end
      tests++; if (param0 !== 32'h0) begin fails++; $display("FAIL midrst_param got %h exp 0", param0); end
      fs0 = 1'b1;
      repeat (65535) tick();
      fs0 = 1'b0;
      bus_read(2'd2, v, d);
      tests++; if (d !== 32'h0000_FFFF) begin fails++; $display("FAIL wrap_ffff got %h exp 0000ffff", d); end
      fs0 = 1'b1;
      repeat (2) tick();
      fs0 = 1'b0;
      bus_read(2'd2, v, d);
      tests++; if (d !== 32'h0000_0001) begin fails++; $display("FAIL wrap_0001 got %h exp 00000001", d); end
   endtask

   task automatic test_write_sync_commit();
      bus1.avs_address = 2'd1; bus1.avs_writedata = 32'h0BAD_F00D; bus1.avs_write = 1'b1;
      tick();
      bus1.avs_write = 1'b0;
      tests++; if (param1 !== 32'h0) begin fails++; $display("FAIL wsync_hold got %h exp 0", param1); end
      tests++; if (pend1 !== 1'b1) begin fails++; $display("FAIL wsync_pending got %h exp 1", pend1); end
      tick();
      tests++; if (param1 !== 32'h0BAD_F00D) begin fails++; $display("FAIL wsync_commit got %h exp 0badf00d", param1); end
      tests++; if (pend1 !== 1'b0) begin fails++; $display("FAIL wsync_pend_clr got %h exp 0", pend1); end
      tests++; if (bypass1 !== 1'b1) begin fails++; $display("FAIL wsync_bypass got %h exp 1", bypass1); end
   endtask

   initial begin
      bus0.avs_address = '0; bus0.avs_write = 1'b0; bus0.avs_writedata = '0; bus0.avs_read = 1'b0;
      bus1.avs_address = '0; bus1.avs_write = 1'b0; bus1.avs_writedata = '0; bus1.avs_read = 1'b0;
      test_reset();
      test_frame_sync();
      test_same_edge();
      test_readback();
      test_read_write_collision();
      test_write_sync_commit();
      test_counter_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/video_core_avs_regs.md
Name: video_core_avs_regs

Overview:
- Avalon-MM responder register block placed inside each video pipeline core (bar core, rgb2gray core); it is the target of the avs_video_*_core_* writes issued by the system control initiator.
- Holds a staged/active pair of control registers and exposes the active copy to the pixel datapath.
- Staged values are committed on a frame boundary so that parameter changes never tear a frame.
- Provides read-back with a fixed one-cycle latency, plus status and ID registers.

Parameters:
- ADDR_W, 2, Avalon word-address width; register map uses addresses 0..3, upper bits ignored.
- CORE_ID, 32'h0000_0000, constant returned by the ID register.
- FRAME_SYNC, 1, 1: commit staged values on frame_start; 0: commit on the cycle after the write.
- CTRL_RST, 32'h0000_0001, reset value of CTRL (bypass=1).
- PARAM_RST, 32'h0000_0000, reset value of PARAM.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-low reset.
- avs_address  in  ADDR_W  word address.
- avs_write  in  1  write strobe, single-cycle, no waitrequest.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe, single-cycle.
- avs_readdata  out  32  read data, valid when avs_readdatavalid=1.
- avs_readdatavalid  out  1  one-cycle pulse per accepted read.
- frame_start  in  1  one-cycle pulse in sys_clk domain at start of frame.
- core_bypass  out  1  active CTRL[0].
- core_param  out  32  active PARAM.
- update_pending  out  1  staged differs from active, awaiting commit.

Behaviour:
- Register map (word address):
  - 0: CTRL, RW, bit0 = bypass, bits31:1 stored.
  - 1: PARAM, RW.
  - 2: STATUS, RO, [15:0] = frame counter, [16] = update_pending.
  - 3: ID, RO, returns CORE_ID.
  - Writes to 2/3 are ignored.
- Reset (sys_rst=0 at a sys_clk edge):
  - staged and active CTRL = CTRL_RST; staged and active PARAM = PARAM_RST.
  - avs_readdata = 0, avs_readdatavalid = 0, update_pending = 0, frame counter = 0.
  - Reset mid-operation discards any pending commit and read.
- Write: avs_write=1 updates the staged register at the edge and sets pending=1.
- Read: avs_read=1 at edge N gives avs_readdatavalid=1 and avs_readdata at N+1.
  - CTRL/PARAM reads return the staged value; STATUS returns the value sampled at edge N.
  - avs_readdata holds its last value when valid=0.
- Simultaneous avs_write and avs_read: the write is performed, the read is dropped (no readdatavalid).
- Commit FRAME_SYNC=1: on a frame_start edge with pending=1, active <= staged and pending <= 0; outputs change on the following cycle.
- Commit FRAME_SYNC=0: commit occurs on the edge after the write (one-cycle latency); frame_start only counts frames.
- Write and frame_start on the same edge (FRAME_SYNC=1):
  - the commit uses the pre-write staged values;
  - the new write lands in staged and pending stays 1, so it commits at the next frame_start.
- Frame counter increments on every frame_start; 16-bit, wraps 0xFFFF to 0x0000.
- Internal two-state FSM: IDLE (pending=0) / PENDING (pending=1).
  - IDLE to PENDING on write.
  - PENDING to IDLE on commit, unless a write arrives on the same edge.
- Out-of-range address bits are ignored; only address[1:0] is decoded.

Decomposition:
- Package video_avs_pkg:
  - register address localparams (REG_CTRL=0, REG_PARAM=1, REG_STATUS=2, REG_ID=3);
  - CTRL bit index constants;
  - a packed struct typedef for CTRL.
- The package is shared with the system avalon control initiator.
- One sub-module, video_shadow_reg: a staged/active register pair with commit enable, instantiated for CTRL and PARAM.

Test Plan:
- Reset: hold sys_rst=0 for 3 cycles, release -> core_bypass=1, core_param=0, update_pending=0; reading address 2 returns 0x0000_0000 one cycle later with valid.
- Frame-synced write (FRAME_SYNC=1): write PARAM=0xDEADBEEF -> update_pending=1 and core_param stays 0. Pulse frame_start -> next cycle core_param=0xDEADBEEF, pending=0.
- Same-edge write and commit:
  - Write CTRL=0 and commit it.
  - Then write CTRL=1 on the same edge as frame_start -> core_bypass stays 0, pending=1.
  - A second frame_start makes core_bypass=1.
- Read-back: write PARAM=0x12345678, read address 1 -> readdatavalid exactly one cycle later with 0x12345678; read address 3 returns CORE_ID; write to address 3 has no effect.
- Read+write same cycle: assert both to address 0 -> no readdatavalid; a subsequent read shows the new staged value.
- Counter wrap: issue 65537 frame_start pulses -> STATUS[15:0]=0x0001; with FRAME_SYNC=0, a write commits to the output one cycle after the write with no frame_start.
